timed_onehot_decoder: RTL and testbench
=======================================

// Module: timed_onehot_decoder
// PURPOSE
//  Parametrised, registered N-to-M one-hot decoder with timed output pulses.
//  Generalises the 2-to-4 enable decoder: address width and output count are parameters.
//  Adds a valid/ready request handshake, pulse and latch modes, and break-before-make gaps.
//  Drives one-hot select/strobe lines (register-file write enables, mux selects) from a
//  control FSM.
// PARAMETERS
//  ADDR_WIDTH  2  address bits; NUM_OUT <= 2**ADDR_WIDTH
//  NUM_OUT     4  number of one-hot outputs
//  CNT_W       4  width of req_len (pulse length in cycles)
//  GAP_CYCLES  1  all-zero cycles inserted between two different driven codes (0 = none)
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           asynchronous active-low reset
//  enable      in   1           global enable; low aborts and blanks outputs
//  clear       in   1           abort current drive (with gap)
//  req_valid   in   1           request present
//  req_addr    in   ADDR_WIDTH  output index to drive
//  req_mode    in   1           0 = pulse, 1 = latch; sampled at accept
//  req_len     in   CNT_W       pulse length in cycles; 0 is treated as 1
//  req_ready   out  1           request can be accepted this cycle
//  out         out  NUM_OUT     registered one-hot outputs
//  busy        out  1           state != IDLE
//  err_addr    out  1           1-cycle pulse: accepted request had req_addr >= NUM_OUT
// BEHAVIOUR
//  Reset (async, any state): out=0, err_addr=0, state=IDLE, counters=0, pending=0.
//  States: IDLE, DRIVE (pulse counting), HOLD (latched), GAP (blanking).
//  req_ready = enable & ~clear & (state==IDLE | state==HOLD) (combinational).
//  Accept = req_valid & req_ready.
//  Bad address (accept, req_addr >= NUM_OUT):
//    err_addr=1 next cycle; state and out unchanged.
//  Good accept in IDLE, latency 1:
//    out = 1<<req_addr on the next edge.
//    Pulse mode -> DRIVE for max(req_len,1) cycles, then out=0.
//      Then GAP for GAP_CYCLES, or IDLE directly if GAP_CYCLES=0.
//    Latch mode -> HOLD; out held indefinitely.
//  Good accept in HOLD:
//    Same addr: no visible change; mode/len re-applied.
//    Different addr: out=0 next edge, request stored as pending, GAP for GAP_CYCLES,
//      then pending code driven exactly as an IDLE accept.
//    GAP_CYCLES=0: switch directly in one edge.
//  GAP: out=0, req_ready=0.
//    Exits to the pending drive if pending=1, else IDLE. Pending is cleared on use.
//  clear=1 (enable=1):
//    out=0 next edge, pending dropped, GAP (or IDLE if GAP_CYCLES=0).
//    Has priority over req_valid the same cycle.
//    clear in IDLE or GAP: no effect beyond req_ready=0.
//  enable=0:
//    out=0 next edge, state=IDLE, pending dropped, no gap; overrides clear and requests.
//  Invariant: out is always zero or one-hot ($onehot0); never two bits in one cycle.
//  Counter: CNT_W-bit down-counter loaded with max(req_len,1)-1; no wrap.
//    Max pulse = 2**CNT_W-1.
// STRUCTURE
//  decoder_defs.vh (shared include): state encodings ST_IDLE/ST_DRIVE/ST_HOLD/ST_GAP,
//    MODE_PULSE/MODE_LATCH constants.
//  Sub-module onehot_decode #(ADDR_WIDTH,NUM_OUT): combinational addr+en -> one-hot,
//    plus an out-of-range flag. Reused elsewhere; the top registers its output.
//  Top: FSM, length/gap counters, pending request register (addr, mode, len).
// TESTING
//  1. enable=0, all 4 addrs requested -> req_ready=0, out=0000 throughout.
//  2. Pulse: addr=2, len=3, GAP=1 -> out=0100 for cycles 1-3, 0000 cycle 4 (GAP),
//     ready=1 cycle 5.
//  3. Latch: addr=1 then addr=3 while HOLD -> 0010, one 0000 gap cycle, then 1000 held.
//     Never 1010.
//  4. NUM_OUT=3 instance, addr=3 -> err_addr pulse 1 cycle, out=000, busy=0.
//  5. clear and req_valid same cycle in HOLD(addr0) -> out=0000 next edge, request not
//     accepted, GAP then IDLE.
//  6. rst_n low mid-DRIVE (addr1, len=8) -> out=0000 immediately (async); len=0 -> 1-cycle
//     pulse. Check $onehot0(out) every cycle.

Source files
------------

// File: rtl/timed_onehot_decoder_pkg.sv
// ============================================================================
// Module  : timed_onehot_decoder_pkg
// Brief   : State encodings and request-mode constants for the timed decoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package timed_onehot_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LATCH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/onehot_decode.sv
// ============================================================================
// Module  : onehot_decode
// Brief   : Combinational address-to-one-hot decoder with out-of-range flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module onehot_decode #(
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_OUT    = 4
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_en,
  output logic [NUM_OUT-1:0]    o_onehot,
  output logic                  o_oor
);

  assign o_oor = (32'(i_addr) >= 32'(NUM_OUT));

  // An out-of-range address matches no bit, so the vector stays all-zero.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_bit
    assign o_onehot[i] = i_en & (i_addr == ADDR_WIDTH'(i));
  end

endmodule

`default_nettype wire

// File: rtl/timed_onehot_decoder.sv
// ============================================================================
// Module  : timed_onehot_decoder
// Brief   : Registered one-hot decoder with pulse/latch drive and blanking gaps.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module timed_onehot_decoder
  import timed_onehot_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_OUT    = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_mode,
  input  logic [CNT_W-1:0]      req_len,
  output logic                  req_ready,
  output logic [NUM_OUT-1:0]    out,
  output logic                  busy,
  output logic                  err_addr
);

  localparam int               c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                  r_state;
  logic [NUM_OUT-1:0]      r_out;
  logic                    r_err;
  logic [CNT_W-1:0]        r_cnt;
  logic [c_gap_w-1:0]      r_gap;
  logic                    r_pend;
  logic [ADDR_WIDTH-1:0]   r_pend_addr;
  logic                    r_pend_mode;
  logic [CNT_W-1:0]        r_pend_len;

  logic                    w_ready;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic                    w_sel_mode;
  logic [CNT_W-1:0]        w_sel_len;
  logic [CNT_W-1:0]        w_sel_cnt;
  logic [NUM_OUT-1:0]      w_onehot;
  logic                    w_oor;
  logic                    w_same;

  assign w_ready  = enable & ~clear & ((r_state == ST_IDLE) | (r_state == ST_HOLD));
  assign w_accept = req_valid & w_ready;

  // One decoder serves both paths: the pending request is only launched from GAP.
  assign w_sel_addr = (r_state == ST_GAP) ? r_pend_addr : req_addr;
  assign w_sel_mode = (r_state == ST_GAP) ? r_pend_mode : req_mode;
  assign w_sel_len  = (r_state == ST_GAP) ? r_pend_len  : req_len;
  assign w_sel_cnt  = (w_sel_len == '0) ? '0 : w_sel_len - 1'b1;

  onehot_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_OUT    (NUM_OUT)
  ) u_decode (
    .i_addr   (w_sel_addr),
    .i_en     (1'b1),
    .o_onehot (w_onehot),
    .o_oor    (w_oor)
  );

  assign w_same = (w_onehot == r_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_mode <= 1'b0;
      r_pend_len  <= '0;
    end else begin
      r_err <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
        r_out   <= '0;
        r_cnt   <= '0;
        r_gap   <= '0;
        r_pend  <= 1'b0;
      end else if (clear && ((r_state == ST_DRIVE) || (r_state == ST_HOLD))) begin
        r_out  <= '0;
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_gap  <= c_gap_load;
        r_state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              if (w_oor) begin
                r_err <= 1'b1;
              end else begin
                r_out   <= w_onehot;
                r_cnt   <= w_sel_cnt;
                r_state <= (w_sel_mode == MODE_LATCH) ? ST_HOLD : ST_DRIVE;
              end
            end
          end
          ST_HOLD: begin
            if (w_accept) begin
              if (w_oor) begin
                r_err <= 1'b1;
              end else if (w_same || (GAP_CYCLES == 0)) begin
                r_out   <= w_onehot;
                r_cnt   <= w_sel_cnt;
                r_state <= (w_sel_mode == MODE_LATCH) ? ST_HOLD : ST_DRIVE;
              end else begin
                // Break before make: blank now, launch the new code after the gap.
                r_out       <= '0;
                r_pend      <= 1'b1;
                r_pend_addr <= req_addr;
                r_pend_mode <= req_mode;
                r_pend_len  <= req_len;
                r_gap       <= c_gap_load;
                r_state     <= ST_GAP;
              end
            end
          end
          ST_DRIVE: begin
            if (r_cnt == '0) begin
              r_out   <= '0;
              r_gap   <= c_gap_load;
              r_state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (r_gap == '0) begin
              if (r_pend) begin
                r_pend  <= 1'b0;
                r_out   <= w_onehot;
                r_cnt   <= w_sel_cnt;
                r_state <= (w_sel_mode == MODE_LATCH) ? ST_HOLD : ST_DRIVE;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready = w_ready;
  assign out       = r_out;
  assign busy      = (r_state != ST_IDLE);
  assign err_addr  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_timed_onehot_decoder.sv
// ============================================================================
// Module  : tb_timed_onehot_decoder
// Brief   : Directed self-checking bench for the timed one-hot decoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timed_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  // Default instance: NUM_OUT=4, GAP_CYCLES=1
  logic       req_valid;
  logic [1:0] req_addr;
  logic       req_mode;
  logic [3:0] req_len;
  logic       req_ready;
  logic [3:0] out;
  logic       busy;
  logic       err_addr;
  // Narrow instance: NUM_OUT=3, GAP_CYCLES=0
  logic       req_valid3;
  logic [1:0] req_addr3;
  logic       req_mode3;
  logic [3:0] req_len3;
  logic       req_ready3;
  logic [2:0] out3;
  logic       busy3;
  logic       err_addr3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  timed_onehot_decoder #(
    .ADDR_WIDTH (2), .NUM_OUT (4), .CNT_W (4), .GAP_CYCLES (1)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .enable (enable), .clear (clear),
    .req_valid (req_valid), .req_addr (req_addr), .req_mode (req_mode),
    .req_len (req_len), .req_ready (req_ready), .out (out), .busy (busy),
    .err_addr (err_addr)
  );

  timed_onehot_decoder #(
    .ADDR_WIDTH (2), .NUM_OUT (3), .CNT_W (4), .GAP_CYCLES (0)
  ) u_dut3 (
    .clk (clk), .rst_n (rst_n), .enable (enable), .clear (clear),
    .req_valid (req_valid3), .req_addr (req_addr3), .req_mode (req_mode3),
    .req_len (req_len3), .req_ready (req_ready3), .out (out3), .busy (busy3),
    .err_addr (err_addr3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] a, input logic m, input logic [3:0] l);
    req_valid = 1'b1;
    req_addr  = a;
    req_mode  = m;
    req_len   = l;
  endtask

  // Outputs must never carry more than one hot bit.
  always @(negedge clk) begin
    chk("onehot0_out",  32'($onehot0(out)),  'h1);
    chk("onehot0_out3", 32'($onehot0(out3)), 'h1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_mode = 1'b0; req_len = '0;
    req_valid3 = 1'b0; req_addr3 = '0; req_mode3 = 1'b0; req_len3 = '0;
    cyc();
    chk("rst_out",  32'(out),      'h0);
    chk("rst_busy", 32'(busy),     'h0);
    chk("rst_err",  32'(err_addr), 'h0);
    chk("rst_out3", 32'(out3),     'h0);
    rst_n = 1'b1;
    cyc();

    // 1: enable low blocks every address
    for (int a = 0; a < 4; a++) begin
      req(2'(a), 1'b1, 4'd1);
      #1 chk("dis_ready", 32'(req_ready), 'h0);
      cyc();
      chk("dis_out", 32'(out), 'h0);
    end
    req_valid = 1'b0;
    enable = 1'b1;
    cyc();

    // 2: pulse addr2 len3
    req(2'd2, 1'b0, 4'd3);
    #1 chk("p_ready0", 32'(req_ready), 'h1);
    cyc();
    req_valid = 1'b0;
    chk("p_c1", 32'(out), 'h4);
    chk("p_busy", 32'(busy), 'h1);
    cyc(); chk("p_c2", 32'(out), 'h4);
    cyc(); chk("p_c3", 32'(out), 'h4);
    cyc(); chk("p_c4", 32'(out), 'h0);
    chk("p_c4_ready", 32'(req_ready), 'h0);
    chk("p_c4_busy", 32'(busy), 'h1);
    cyc(); chk("p_c5_ready", 32'(req_ready), 'h1);
    chk("p_c5_busy", 32'(busy), 'h0);

    // 3: latch addr1 then addr3 from HOLD
    req(2'd1, 1'b1, 4'd0);
    cyc(); req_valid = 1'b0;
    chk("l_a1", 32'(out), 'h2);
    chk("l_hold_ready", 32'(req_ready), 'h1);
    cyc(); chk("l_a1_held", 32'(out), 'h2);
    req(2'd3, 1'b1, 4'd0);
    cyc(); req_valid = 1'b0;
    chk("l_gap", 32'(out), 'h0);
    chk("l_gap_ready", 32'(req_ready), 'h0);
    cyc(); chk("l_a3", 32'(out), 'h8);
    cyc(); chk("l_a3_held", 32'(out), 'h8);
    chk("l_a3_busy", 32'(busy), 'h1);

    // 5: move to HOLD(addr0), then clear collides with a request
    req(2'd0, 1'b1, 4'd0);
    cyc(); req_valid = 1'b0;
    cyc(); chk("c_a0", 32'(out), 'h1);
    clear = 1'b1;
    req(2'd2, 1'b1, 4'd0);
    #1 chk("c_ready", 32'(req_ready), 'h0);
    cyc(); clear = 1'b0; req_valid = 1'b0;
    chk("c_out", 32'(out), 'h0);
    chk("c_gap_busy", 32'(busy), 'h1);
    cyc(); chk("c_idle_busy", 32'(busy), 'h0);
    cyc(); chk("c_no_accept", 32'(out), 'h0);

    // enable drop from HOLD: blank and idle without a gap
    req(2'd2, 1'b1, 4'd0);
    cyc(); req_valid = 1'b0;
    chk("e_a2", 32'(out), 'h4);
    enable = 1'b0;
    cyc(); enable = 1'b1;
    chk("e_out", 32'(out), 'h0);
    chk("e_busy", 32'(busy), 'h0);

    // 4: NUM_OUT=3 instance, bad address then direct switch without gap
    req_valid3 = 1'b1; req_addr3 = 2'd3; req_mode3 = 1'b1; req_len3 = 4'd1;
    cyc(); req_valid3 = 1'b0;
    chk("b_err", 32'(err_addr3), 'h1);
    chk("b_out", 32'(out3), 'h0);
    chk("b_busy", 32'(busy3), 'h0);
    cyc(); chk("b_err_clr", 32'(err_addr3), 'h0);
    req_valid3 = 1'b1; req_addr3 = 2'd0; req_mode3 = 1'b1;
    cyc(); chk("n_a0", 32'(out3), 'h1);
    req_addr3 = 2'd2;
    cyc(); req_valid3 = 1'b0;
    chk("n_a2_direct", 32'(out3), 'h4);
    req_valid3 = 1'b1; req_addr3 = 2'd2; req_mode3 = 1'b0; req_len3 = 4'd2;
    cyc(); req_valid3 = 1'b0;
    chk("n_same_pulse1", 32'(out3), 'h4);
    cyc(); chk("n_same_pulse2", 32'(out3), 'h4);
    cyc(); chk("n_end_out", 32'(out3), 'h0);
    chk("n_end_busy", 32'(busy3), 'h0);

    // 6: async reset mid-drive, then zero-length pulse
    req(2'd1, 1'b0, 4'd8);
    cyc(); req_valid = 1'b0;
    chk("r_a1", 32'(out), 'h2);
    cyc(); cyc();
    chk("r_a1_mid", 32'(out), 'h2);
    rst_n = 1'b0;
    #1 chk("r_async_out", 32'(out), 'h0);
    chk("r_async_busy", 32'(busy), 'h0);
    cyc(); rst_n = 1'b1;
    cyc();
    req(2'd0, 1'b0, 4'd0);
    cyc(); req_valid = 1'b0;
    chk("z_c1", 32'(out), 'h1);
    cyc(); chk("z_c2", 32'(out), 'h0);
    chk("z_gap_busy", 32'(busy), 'h1);
    cyc(); chk("z_idle", 32'(busy), 'h0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
